// File: rtl/mux_rr_n.sv
// N-channel buffered multiplexer. Each input channel feeds its own small FIFO;
// a single registered output port drains the FIFOs either round-robin
// (work-conserving, MODE=0) or in fixed TDM slots (MODE=1).
module mux_rr_n #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int DEPTH = 4,
  parameter int MODE  = 0
) (
  input  logic                   clk_f,
  input  logic                   reset,
  input  logic [N-1:0]           in_valid,
  input  logic [N*WIDTH-1:0]     in_data,
  output logic [N-1:0]           in_ready,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       out_data,
  output logic [$clog2(N)-1:0]   out_ch,
  input  logic                   out_ready,
  output logic [N-1:0]           ovf
);

  localparam int CW = $clog2(N);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [CW:0] NCH  = (CW+1)'(N);

  logic [AW:0]      count  [N];
  logic [AW-1:0]    wr_ptr [N];
  logic [AW-1:0]    rd_ptr [N];
  logic [WIDTH-1:0] mem    [N][DEPTH];

  logic [N-1:0]  nonempty;
  logic [N-1:0]  push;
  logic [N-1:0]  pop;
  logic [CW-1:0] ptr;
  logic [CW-1:0] sel;
  logic [CW-1:0] sel_next;
  logic [CW:0]   cand;
  logic          found;
  logic          advance;

  // Output register moves whenever it is empty or being consumed.
  assign advance = !out_valid || out_ready;

  // Per-channel status from registered counts only; pushes gated by room.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      nonempty[i] = (count[i] != '0);
      in_ready[i] = (count[i] != FULL);
      push[i]     = in_valid[i] && in_ready[i];
    end
  end

  // Channel selection: round-robin scan from ptr, or the TDM slot at ptr.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    found = 1'b0;
    sel   = ptr;
    cand  = '0;
    pop   = '0;
    if (MODE == 1) begin
      found = nonempty[ptr];
    end else begin
      for (int k = 0; k < N; k++) begin
        cand = {1'b0, ptr} + (CW+1)'(k);
        if (cand >= NCH) cand = cand - NCH;
        if (!found && nonempty[cand[CW-1:0]]) begin
          found = 1'b1;
          sel   = cand[CW-1:0];
        end
      end
    end
    if (advance && found) pop[sel] = 1'b1;
  end

  assign sel_next = (sel == CW'(N - 1)) ? '0 : sel + 1'b1;

  // FIFO bookkeeping: pointers wrap naturally, count tracks push minus pop.
  always_ff @(posedge clk_f or posedge reset) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        count[i]  <= '0;
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
        if (push[i] && !pop[i])      count[i] <= count[i] + 1'b1;
        else if (!push[i] && pop[i]) count[i] <= count[i] - 1'b1;
      end
    end
  end

  // FIFO storage writes.
  always_ff @(posedge clk_f) begin
    // NOTE: storage is deliberately not reset; the zeroed counts make every
    // stale word unreachable, and leaving it out keeps the array a plain RAM.
    for (int i = 0; i < N; i++) begin
      if (push[i]) mem[i][wr_ptr[i]] <= in_data[i*WIDTH +: WIDTH];
    end
  end

  // Sticky overflow: a word offered to a full FIFO is dropped and flagged.
  always_ff @(posedge clk_f or posedge reset) begin
    if (reset) ovf <= '0;
    else       ovf <= ovf | (in_valid & ~in_ready);
  end

  // Output register and arbitration pointer.
  always_ff @(posedge clk_f or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      ptr       <= '0;
    end else if (advance) begin
      if (found) begin
        out_valid <= 1'b1;
        out_data  <= mem[sel][rd_ptr[sel]];
        out_ch    <= sel;
        ptr       <= sel_next;
      end else begin
        out_valid <= 1'b0;
        // A TDM slot is consumed even when it carries nothing.
        if (MODE == 1) ptr <= sel_next;
      end
    end
  end

endmodule

// File: tb/tb_mux_rr_n.sv
// Bench for mux_rr_n: one round-robin and one TDM instance share stimulus and
// are compared every cycle against a queue-based reference, plus directed
// expectations for the reset, rotation, skip, bubble, overflow and reset cases.
module tb_mux_rr_n;

  localparam int W = 8;
  localparam int N = 4;
  localparam int D = 4;

  logic           clk_f     = 1'b0;
  logic           reset     = 1'b1;
  logic [N-1:0]   in_valid  = '0;
  logic [N*W-1:0] in_data   = '0;
  logic           out_ready = 1'b1;

  logic [N-1:0] in_ready  [2];
  logic         out_valid [2];
  logic [W-1:0] out_data  [2];
  logic [1:0]   out_ch    [2];
  logic [N-1:0] ovf       [2];

  mux_rr_n #(.WIDTH(W), .N(N), .DEPTH(D), .MODE(0)) u_rr (
    .clk_f(clk_f), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready[0]), .out_valid(out_valid[0]), .out_data(out_data[0]),
    .out_ch(out_ch[0]), .out_ready(out_ready), .ovf(ovf[0]));

  mux_rr_n #(.WIDTH(W), .N(N), .DEPTH(D), .MODE(1)) u_tdm (
    .clk_f(clk_f), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready[1]), .out_valid(out_valid[1]), .out_data(out_data[1]),
    .out_ch(out_ch[1]), .out_ready(out_ready), .ovf(ovf[1]));

  always #5 clk_f = ~clk_f;

  // Reference state: index d = 0 round-robin, d = 1 TDM.
  logic [W-1:0] mq [2*N][$];
  logic         m_ov  [2];
  logic [W-1:0] m_od  [2];
  int           m_oc  [2];
  int           m_ptr [2];
  logic [N-1:0] m_ovf [2];

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int q = 0; q < 2*N; q++) mq[q].delete();
    for (int d = 0; d < 2; d++) begin
      m_ov[d] = 1'b0; m_od[d] = '0; m_oc[d] = 0; m_ptr[d] = 0; m_ovf[d] = '0;
    end
  endtask

  // One clock edge of the reference, decided entirely from pre-edge state.
  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      bit adv;
      bit found;
      int sel;
      bit [N-1:0] acc;
      adv   = !m_ov[d] || out_ready;
      found = 1'b0;
      sel   = m_ptr[d];
      if (d == 0) begin
        for (int k = 0; k < N; k++) begin
          int c;
          c = (m_ptr[d] + k) % N;
          if (!found && mq[d*N+c].size() != 0) begin found = 1'b1; sel = c; end
        end
      end else begin
        found = (mq[d*N+sel].size() != 0);
      end
      acc = '0;
      for (int c = 0; c < N; c++) begin
        if (in_valid[c]) begin
          if (mq[d*N+c].size() < D) acc[c] = 1'b1;
          else                      m_ovf[d][c] = 1'b1;
        end
      end
      if (adv) begin
        if (found) begin
          m_od[d]  = mq[d*N+sel].pop_front();
          m_ov[d]  = 1'b1;
          m_oc[d]  = sel;
          m_ptr[d] = (sel + 1) % N;
        end else begin
          m_ov[d] = 1'b0;
          if (d == 1) m_ptr[d] = (m_ptr[d] + 1) % N;
        end
      end
      for (int c = 0; c < N; c++)
        if (acc[c]) mq[d*N+c].push_back(in_data[c*W +: W]);
    end
  endtask

  task automatic compare_all();
    for (int d = 0; d < 2; d++) begin
      logic [N-1:0] rdy;
      for (int c = 0; c < N; c++) rdy[c] = (mq[d*N+c].size() < D);
      check($sformatf("m%0d out_valid", d), out_valid[d], m_ov[d]);
      check($sformatf("m%0d out_data", d),  out_data[d],  m_od[d]);
      check($sformatf("m%0d out_ch", d),    out_ch[d],    m_oc[d]);
      check($sformatf("m%0d in_ready", d),  in_ready[d],  rdy);
      check($sformatf("m%0d ovf", d),       ovf[d],       m_ovf[d]);
    end
  endtask

  task automatic step();
    @(posedge clk_f);
    model_edge();
    #1;
    compare_all();
  endtask

  // Asynchronous reset pulse between edges; values checked while it is held.
  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    #1;
    compare_all();
    for (int d = 0; d < 2; d++) begin
      check("reset out_valid", out_valid[d], 1'b0);
      check("reset out_ch",    out_ch[d],    2'd0);
      check("reset out_data",  out_data[d],  8'h00);
      check("reset in_ready",  in_ready[d],  4'hF);
      check("reset ovf",       ovf[d],       4'h0);
    end
    #10;
    reset = 1'b0;
  endtask

  initial begin
    // Reset state.
    do_reset();

    // Round-robin rotation over all four channels.
    do_reset();
    out_ready = 1'b1;
    in_valid  = 4'hF;
    in_data   = {8'hFD, 8'hFF, 8'h01, 8'hEE};
    step();
    in_valid = '0;
    step();
    check("rr0 valid", out_valid[0], 1'b1);
    check("rr0 data",  out_data[0],  8'hEE);
    check("rr0 ch",    out_ch[0],    2'd0);
    step();
    check("rr1 data", out_data[0], 8'h01);
    check("rr1 ch",   out_ch[0],   2'd1);
    step();
    check("rr2 data", out_data[0], 8'hFF);
    check("rr2 ch",   out_ch[0],   2'd2);
    step();
    check("rr3 data", out_data[0], 8'hFD);
    check("rr3 ch",   out_ch[0],   2'd3);
    step();
    check("rr drained", out_valid[0], 1'b0);

    // Round-robin skips empty channels.
    do_reset();
    in_valid = 4'b0100;
    in_data  = {8'h00, 8'h10, 8'h00, 8'h00};
    step();
    in_valid = '0;
    step();
    check("skip valid", out_valid[0], 1'b1);
    check("skip ch",    out_ch[0],    2'd2);
    check("skip data",  out_data[0],  8'h10);
    step();
    check("skip after", out_valid[0], 1'b0);

    // TDM bubbles: only slot 1 carries data.
    do_reset();
    in_valid = 4'b0010;
    in_data  = {8'h00, 8'h00, 8'h22, 8'h00};
    step();
    check("tdm slot0", out_valid[1], 1'b0);
    in_valid = '0;
    step();
    check("tdm slot1 valid", out_valid[1], 1'b1);
    check("tdm slot1 ch",    out_ch[1],    2'd1);
    check("tdm slot1 data",  out_data[1],  8'h22);
    step();
    check("tdm slot2", out_valid[1], 1'b0);
    step();
    check("tdm slot3", out_valid[1], 1'b0);

    // Backpressure and overflow on channel 0.
    do_reset();
    out_ready = 1'b0;
    for (int j = 0; j < 6; j++) begin
      in_valid = 4'b0001;
      in_data  = {24'h0, 8'(8'hA0 + j)};
      step();
    end
    in_valid = '0;
    check("bp in_ready0", in_ready[0][0], 1'b0);
    check("bp ovf0",      ovf[0][0],      1'b1);
    check("bp held data", out_data[0],    8'hA0);
    step();
    check("bp still held", out_data[0], 8'hA0);
    out_ready = 1'b1;
    for (int j = 1; j <= 4; j++) begin
      step();
      check("bp drain data", out_data[0], 32'(8'hA0 + j));
      check("bp drain ch",   out_ch[0],   2'd0);
    end
    step();
    check("bp drained", out_valid[0], 1'b0);

    // Mid-operation reset discards queued words.
    do_reset();
    out_ready = 1'b0;
    in_valid  = 4'hF;
    in_data   = $urandom;
    step();
    in_data   = $urandom;
    step();
    in_valid = '0;
    do_reset();
    out_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      step();
      check("post-reset rr idle",  out_valid[0], 1'b0);
      check("post-reset tdm idle", out_valid[1], 1'b0);
    end
    do_reset();
    in_valid = 4'b1001;
    in_data  = {8'h33, 16'h0, 8'h44};
    step();
    in_valid = '0;
    step();
    check("post-reset first ch",   out_ch[0],   2'd0);
    check("post-reset first data", out_data[0], 8'h44);

    // Randomized traffic with occasional asynchronous resets.
    for (int j = 0; j < 600; j++) begin
      in_valid  = 4'($urandom);
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 149) == 0) do_reset();
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_rr_n.md
MUX_RR_N -- requirements
Module: mux_rr_n

Interface
REQ-001 The block SHALL have the parameter WIDTH, default 8, giving the data width per channel in bits.
REQ-002 The block SHALL have the parameter N, default 4, giving the channel count (2..16).
REQ-003 The block SHALL have the parameter DEPTH, default 4, giving the per-channel FIFO depth in words (power of 2, at least 2).
REQ-004 The block SHALL have the parameter MODE, default 0, selecting the arbitration mode: 0 = work-conserving round-robin, 1 = fixed TDM slot.
REQ-005 The block SHALL have the port clk_f, input, width 1: the single block clock; all state updates on its rising edge.
REQ-006 The block SHALL have the port reset, input, width 1: reset, asynchronous, active-high.
REQ-007 The block SHALL have the port in_valid, input, width N: per-channel input word valid.
REQ-008 The block SHALL have the port in_data, input, width N*WIDTH: channel i data at bits [i*WIDTH +: WIDTH].
REQ-009 The block SHALL have the port in_ready, output, width N: per-channel "FIFO not full".
REQ-010 The block SHALL have the port out_valid, output, width 1: registered output word valid.
REQ-011 The block SHALL have the port out_data, output, width WIDTH: registered output word.
REQ-012 The block SHALL have the port out_ch, output, width clog2(N): source channel of out_data.
REQ-013 The block SHALL have the port out_ready, input, width 1: downstream accept.
REQ-014 The block SHALL have the port ovf, output, width N: per-channel sticky overflow flag.

Function
REQ-015 Each channel SHALL own a DEPTH-word FIFO with a registered occupancy count; in_ready[i] = (count[i] != DEPTH), derived from registered state only.
REQ-016 A push to channel i SHALL occur when in_valid[i] and in_ready[i] are both high at a clk_f edge; there SHALL be no push otherwise.
REQ-017 When in_valid[i] is high and in_ready[i] is low, the word SHALL be discarded and ovf[i] set to 1; ovf[i] SHALL hold until reset.
REQ-018 The output register SHALL "advance" on an edge where out_valid==0 or out_ready==1; when out_valid==1 and out_ready==0, out_data, out_ch, out_valid and the pointer SHALL be held.
REQ-019 MODE=0: on advance, the selected channel SHALL be the first non-empty channel scanning ptr, ptr+1, ... mod N; that channel pops, out_valid<=1, out_ch<=sel, ptr<=(sel+1) mod N.
REQ-020 MODE=0: on advance with all FIFOs empty, out_valid<=0, with out_data, out_ch and ptr unchanged.
REQ-021 MODE=1: on every advance, channel ptr is examined; if non-empty it pops with out_valid<=1 and out_ch<=ptr, else out_valid<=0; ptr<=(ptr+1) mod N in both cases.
REQ-022 Push-to-output latency SHALL be 1 cycle minimum: a word pushed at edge k into an empty system appears with out_valid=1 after edge k+1 (MODE=0).
REQ-023 There SHALL be no bypass: an empty FIFO SHALL NOT be popped in the cycle it is pushed.
REQ-024 A simultaneous push and pop on one channel SHALL leave its count unchanged and preserve FIFO order.
REQ-025 FIFO read/write pointers SHALL wrap modulo DEPTH; the count SHALL never exceed DEPTH nor underflow.
REQ-026 Per-channel order SHALL be preserved; no word SHALL be duplicated or lost except per REQ-017.

Reset
REQ-027 While reset=1 (asynchronously): out_valid=0, out_data=0, out_ch=0, ptr=0, all counts/pointers=0, ovf=0, in_ready=all ones.
REQ-028 Reset asserted mid-operation SHALL discard all buffered words; the first advance after release SHALL examine channel 0.

Verification
REQ-029 The bench SHALL cover reset state: N=4, reset pulse -> out_valid=0, out_ch=0, in_ready=4'hF, ovf=0.
REQ-030 The bench SHALL cover MODE=0 round-robin: one push each of ch0..3 = EE,01,FF,FD with out_ready=1 -> out_data EE,01,FF,FD on 4 consecutive cycles, out_ch 0,1,2,3.
REQ-031 The bench SHALL cover MODE=0 skip: only ch2 holds 8'h10 -> out_valid=1, out_ch=2 one cycle after the push, then out_valid=0.
REQ-032 The bench SHALL cover MODE=1 bubbles: only ch1 holds 8'h22, starting from ptr=0 -> cycles yield valid 0,1,0,0 with out_ch=1 on the valid slot.
REQ-033 The bench SHALL cover backpressure/overflow: out_ready=0 and 6 pushes into ch0 (DEPTH=4) -> in_ready[0]=0 after the 4th buffered word, ovf[0]=1, out_data held; after out_ready=1, words are emitted in order with none duplicated.
REQ-034 The bench SHALL cover mid-operation reset: reset with words queued -> all outputs return to REQ-027 values and no stale word is emitted afterwards.
